prefetch_unit: RTL and testbench
================================

PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 Parameter ADDR_W, default 16, instruction word-address width.
REQ-002 Parameter INSTR_W, default 32, instruction width.
REQ-003 Parameter DEPTH, default 4, queue entries; power of two, at least 2.
REQ-004 Parameter RESET_VEC, default 0, fetch address after reset.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 redirect  in  1  flush queue and restart fetch at pc_in.
REQ-008 pc_in  in  ADDR_W  redirect target.
REQ-009 deq  in  1  core consumes head entry.
REQ-010 out_valid  out  1  head entry valid.
REQ-011 out_instr  out  INSTR_W  head instruction.
REQ-012 out_addr  out  ADDR_W  address of head instruction.
REQ-013 mem_req  out  1  fetch request to memory arbiter.
REQ-014 mem_addr  out  ADDR_W  fetch address.
REQ-015 mem_cack  in  1  arbiter accepted request this cycle.
REQ-016 mem_ready  in  1  mem_data valid this cycle.
REQ-017 mem_data  in  INSTR_W  returned instruction.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, WAIT and DROP, with at most one outstanding request.
REQ-019 IDLE->REQ when count plus outstanding is below DEPTH; mem_req=1 only in REQ; mem_addr=fetch_pc.
REQ-020 REQ->WAIT on mem_cack; fetch_pc increments by 1 modulo 2^ADDR_W, wrapping from all-ones to 0.
REQ-021 WAIT->IDLE on mem_ready; mem_data and its address are written into the queue tail.
REQ-022 The queue SHALL be a registered FIFO; data written on mem_ready at cycle M SHALL appear at out_valid/out_instr at M+1 when the queue was empty.
REQ-023 deq with out_valid=1 SHALL pop the head; deq with an empty queue SHALL be ignored.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; count SHALL never exceed DEPTH.
REQ-025 When the queue is full, no new request SHALL be issued; the FSM stays in IDLE.
REQ-026 On redirect, the queue SHALL be emptied, with out_valid=0 the next cycle, and fetch_pc SHALL take pc_in.
REQ-027 Redirect in REQ without mem_cack: the FSM stays in REQ and mem_addr=pc_in next cycle.
REQ-028 Redirect in WAIT, or in REQ with mem_cack, SHALL go to DROP; DROP discards the next mem_ready and then goes to IDLE.
REQ-029 Redirect SHALL take priority over deq and over a same-cycle mem_ready write; that data is dropped.
REQ-030 Redirect in IDLE: mem_req=1 with mem_addr=pc_in at the next cycle.
REQ-031 mem_ready outside WAIT or DROP SHALL be ignored.

Reset
REQ-032 With rst=1 at a rising edge: FSM=IDLE, fetch_pc=RESET_VEC, count=0, pointers=0, out_valid=0 and mem_req=0, regardless of any outstanding request.
REQ-033 rst SHALL take priority over redirect, deq and mem_ready in the same cycle.
REQ-034 The first mem_req after reset SHALL be at the second cycle after rst deasserts, with mem_addr=RESET_VEC.

Structure
REQ-035 The FSM state encoding and the default parameter values SHALL be placed in shared package pcpu_pkg.
REQ-036 The queue SHALL be a sub-module instr_fifo, parametrised by WIDTH (ADDR_W+INSTR_W) and DEPTH, with a flush input.
REQ-037 The design SHALL contain no latches and no combinational path from mem_ready to out_valid.

Verification
REQ-038 Reset, mem_cack=1 on each request, mem_ready one cycle after accept -> addresses 0,1,2,3 fetched in order; deq every cycle yields out_addr 0,1,2,3.
REQ-039 No deq, DEPTH=4 -> exactly 4 requests, then mem_req stays 0; one deq -> exactly one new request, mem_addr=4.
REQ-040 Redirect pc_in=0x0100 while in WAIT -> the stale mem_ready is discarded, the next mem_addr is 0x0100, and the first out_addr is 0x0100.
REQ-041 Redirect to 0x0200 in the same cycle as mem_ready and deq -> out_valid=0 next cycle, with no stale entry visible afterwards.
REQ-042 Redirect to 0xFFFF, then fetch 3 instructions -> mem_addr sequence 0xFFFF, 0x0000, 0x0001.
REQ-043 rst asserted during WAIT -> all outputs reset next cycle; the late mem_ready is ignored and the first request is at RESET_VEC.

Source files
------------

// File: rtl/pcpu_pkg.sv
// Shared definitions for the instruction prefetch unit: default parameter
// values and the fetch FSM state encoding.
package pcpu_pkg;

  localparam int unsigned DEF_ADDR_W    = 16;
  localparam int unsigned DEF_INSTR_W   = 32;
  localparam int unsigned DEF_DEPTH     = 4;
  localparam int unsigned DEF_RESET_VEC = 0;

  // IDLE: no request outstanding; REQ: mem_req asserted;
  // WAIT: accepted, data pending; DROP: accepted, data to be discarded.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/prefetch_unit_if.sv
// Core/memory-side signal bundle of the prefetch unit.
//   core side : redirect, pc_in, deq -> ; <- out_valid, out_instr, out_addr
//   mem side  : <- mem_req, mem_addr ; mem_cack, mem_ready, mem_data ->
// slave  : the prefetch unit's view.
// master : the view of whatever drives core and memory (core + arbiter).
interface prefetch_unit_if
  import pcpu_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned INSTR_W = DEF_INSTR_W
) ();

  logic               redirect;
  logic [ADDR_W-1:0]  pc_in;
  logic               deq;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_addr;
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_cack;
  logic               mem_ready;
  logic [INSTR_W-1:0] mem_data;

  modport slave (
    input  redirect, pc_in, deq, mem_cack, mem_ready, mem_data,
    output out_valid, out_instr, out_addr, mem_req, mem_addr
  );

  modport master (
    output redirect, pc_in, deq, mem_cack, mem_ready, mem_data,
    input  out_valid, out_instr, out_addr, mem_req, mem_addr
  );

endinterface

// File: rtl/instr_fifo.sv
// Registered FIFO holding fetched {address, instruction} entries.
//   clk, rst     : clock, synchronous active-high reset
//   flush_i      : empty the queue (wins over push and pop)
//   push_i/data_i: write tail (ignored when full unless popping)
//   pop_i        : remove head (ignored when empty)
//   valid_o      : head entry valid (registered)
//   full_o       : DEPTH entries held (registered)
//   data_o       : head entry
module instr_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d, full_q, full_d;
  logic             do_push, do_pop;

  // Next-state: flush first, then pop/push (pointers wrap as DEPTH is 2^n)
  always_comb begin
    do_pop   = pop_i && valid_q && !flush_i;
    do_push  = push_i && (!full_q || do_pop) && !flush_i;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
    valid_d = (count_d != '0);
    full_d  = (count_d == CNT_W'(DEPTH));
  end

  // Control state
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
    end
  end

  // Storage array, no reset needed: entries are only read while valid
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign valid_o = valid_q;
  assign full_o  = full_q;
  assign data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: fetches sequential instruction words from a
// memory arbiter (one request outstanding at most) into a small queue the
// core drains; redirect flushes the queue and restarts at a new address.
//   clk, rst : clock, synchronous active-high reset
//   bus      : core side (redirect, pc_in, deq, out_*) and
//              memory side (mem_req, mem_addr, mem_cack, mem_ready, mem_data)
module prefetch_unit
  import pcpu_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned INSTR_W   = DEF_INSTR_W,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned RESET_VEC = DEF_RESET_VEC
) (
  input logic            clk,
  input logic            rst,
  prefetch_unit_if.slave bus
);

  localparam int unsigned WIDTH = ADDR_W + INSTR_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              mem_req_q;
  logic [ADDR_W-1:0] req_addr;
  logic              push;
  logic              fifo_valid, fifo_full;
  logic [WIDTH-1:0]  fifo_head;

  // fetch_pc already advanced on accept, so the outstanding address is one back
  assign req_addr = fetch_pc_q - ADDR_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= ADDR_W'(RESET_VEC);
      mem_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= (state_d == ST_REQ);
    end
  end

  // Next-state and queue write
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    if (bus.redirect) begin
      fetch_pc_d = bus.pc_in;
      case (state_q)
        ST_IDLE: state_d = ST_REQ;
        ST_REQ:  state_d = bus.mem_cack ? ST_DROP : ST_REQ;
        // Data arriving with the redirect is dropped and closes the
        // outstanding request, so fetching can restart immediately.
        ST_WAIT,
        ST_DROP: state_d = bus.mem_ready ? ST_REQ : ST_DROP;
        default: state_d = ST_IDLE;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: if (!fifo_full) state_d = ST_REQ;
        ST_REQ: begin
          if (bus.mem_cack) begin
            state_d    = ST_WAIT;
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
          end
        end
        ST_WAIT: begin
          if (bus.mem_ready) begin
            state_d = ST_IDLE;
            push    = 1'b1;
          end
        end
        ST_DROP: if (bus.mem_ready) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  instr_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (bus.redirect),
    .push_i  (push),
    .data_i  ({req_addr, bus.mem_data}),
    .pop_i   (bus.deq),
    .valid_o (fifo_valid),
    .full_o  (fifo_full),
    .data_o  (fifo_head)
  );

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = fetch_pc_q;
  assign bus.out_valid = fifo_valid;
  assign bus.out_addr  = fifo_head[WIDTH-1:INSTR_W];
  assign bus.out_instr = fifo_head[INSTR_W-1:0];

endmodule

// File: tb/tb_prefetch_unit.sv
// Bench for prefetch_unit: a cycle driver plays core and memory, a
// scoreboard queue holds the entries the queue should present to the core.
module tb_prefetch_unit;

  localparam int unsigned AW    = 16;
  localparam int unsigned IW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [AW-1:0] RVEC = 16'h0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prefetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

  prefetch_unit #(
    .ADDR_W    (AW),
    .INSTR_W   (IW),
    .DEPTH     (DEPTH),
    .RESET_VEC (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [AW+IW-1:0] exp_q[$];
  logic [AW-1:0]    acc_q[$];
  logic [AW-1:0]    pop_log[$];

  bit            auto_cack, cack_rand, deq_drv;
  int            lat;
  bit            pend, pend_stale;
  int            pend_cnt;
  logic [AW-1:0] pend_addr;

  function automatic logic [IW-1:0] data_of(input logic [AW-1:0] a);
    return {a ^ 16'hC3A5, a};
  endfunction

  function automatic logic [AW-1:0] acc_at(input int i);
    return (i < acc_q.size()) ? acc_q[i] : 'x;
  endfunction

  function automatic logic [AW-1:0] pop_at(input int i);
    return (i < pop_log.size()) ? pop_log[i] : 'x;
  endfunction

  // One clock: check out_valid, play memory + core, advance to edge + 1
  task automatic tick(input bit rd, input logic [AW-1:0] pc);
    bit               deliver, cack;
    logic [AW+IW-1:0] head;
    n_checks++;
    if (bus.out_valid !== (exp_q.size() != 0))
      $display("FAIL out_valid: got %b want %b at %0t", bus.out_valid, exp_q.size() != 0, $time);
    else n_pass++;
    deliver = 1'b0;
    if (pend) begin
      if (pend_cnt <= 1) begin deliver = 1'b1; pend = 1'b0; end
      else pend_cnt--;
    end
    bus.mem_ready = deliver;
    bus.mem_data  = deliver ? data_of(pend_addr) : 32'hDEAD_BEEF;
    if (deliver && !pend_stale && !rd && !rst)
      exp_q.push_back({pend_addr, data_of(pend_addr)});
    cack = !rst && (bus.mem_req === 1'b1) &&
           (cack_rand ? ($urandom_range(0, 1) == 1) : auto_cack);
    bus.mem_cack = cack;
    if (cack) begin
      acc_q.push_back(bus.mem_addr);
      pend = 1'b1; pend_cnt = lat; pend_addr = bus.mem_addr; pend_stale = rd;
    end else if (pend && (rd || rst)) begin
      pend_stale = 1'b1;
    end
    bus.deq      = deq_drv;
    bus.redirect = rd;
    bus.pc_in    = pc;
    if (rst || rd) exp_q.delete();
    else if (deq_drv && bus.out_valid === 1'b1 && exp_q.size() != 0) begin
      head = exp_q.pop_front();
      n_checks++;
      if ({bus.out_addr, bus.out_instr} !== head)
        $display("FAIL pop_entry: got %h/%h want %h/%h", bus.out_addr, bus.out_instr,
                 head[AW+IW-1:IW], head[IW-1:0]);
      else n_pass++;
      pop_log.push_back(bus.out_addr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_acc(input int n, input int budget);
    int k = 0;
    while (acc_q.size() < n && k < budget) begin tick(1'b0, '0); k++; end
    n_checks++;
    if (acc_q.size() < n) $display("FAIL acc_timeout: got %0d accepts want %0d", acc_q.size(), n);
    else n_pass++;
  endtask

  task automatic run_until_pops(input int n, input int budget);
    int k = 0;
    while (pop_log.size() < n && k < budget) begin tick(1'b0, '0); k++; end
    n_checks++;
    if (pop_log.size() < n) $display("FAIL pop_timeout: got %0d pops want %0d", pop_log.size(), n);
    else n_pass++;
  endtask

  // Reset long enough to retire any stale memory response, then release
  task automatic do_reset();
    rst = 1'b1; auto_cack = 1'b0; cack_rand = 1'b0; deq_drv = 1'b0; lat = 1;
    repeat (4) tick(1'b0, '0);
    rst = 1'b0;
    acc_q.delete();
    pop_log.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.mem_req !== 1'b0) $display("FAIL rst_mem_req: got %b want 0", bus.mem_req); else n_pass++;
    // rst wins over redirect and deq in the same cycle
    rst = 1'b1; deq_drv = 1'b1;
    tick(1'b1, 16'h1234);
    rst = 1'b0; deq_drv = 1'b0;
    n_checks++;
    if (bus.mem_addr !== RVEC) $display("FAIL rst_over_redirect: got %h want %h", bus.mem_addr, RVEC); else n_pass++;
    n_checks++;
    if (bus.mem_req !== 1'b0) $display("FAIL rst_first_cycle: got %b want 0", bus.mem_req); else n_pass++;
    tick(1'b0, '0);
    n_checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== RVEC)
      $display("FAIL first_req: got %b/%h want 1/%h", bus.mem_req, bus.mem_addr, RVEC);
    else n_pass++;
  endtask

  task automatic test_sequential();
    do_reset();
    auto_cack = 1'b1; lat = 1; deq_drv = 1'b1;
    run_until_pops(4, 60);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (acc_at(i) !== AW'(i)) $display("FAIL seq_fetch[%0d]: got %h want %h", i, acc_at(i), AW'(i));
      else n_pass++;
      n_checks++;
      if (pop_at(i) !== AW'(i)) $display("FAIL seq_out[%0d]: got %h want %h", i, pop_at(i), AW'(i));
      else n_pass++;
    end
  endtask

  task automatic test_full();
    do_reset();
    auto_cack = 1'b1; lat = 1; deq_drv = 1'b0;
    repeat (40) tick(1'b0, '0);
    n_checks++;
    if (acc_q.size() != DEPTH) $display("FAIL full_req_count: got %0d want %0d", acc_q.size(), DEPTH); else n_pass++;
    n_checks++;
    if (bus.mem_req !== 1'b0) $display("FAIL full_no_req: got %b want 0", bus.mem_req); else n_pass++;
    n_checks++;
    if (bus.out_addr !== 16'h0000) $display("FAIL full_head: got %h want 0000", bus.out_addr); else n_pass++;
    deq_drv = 1'b1;
    tick(1'b0, '0);
    deq_drv = 1'b0;
    repeat (40) tick(1'b0, '0);
    n_checks++;
    if (acc_q.size() != DEPTH + 1) $display("FAIL refill_count: got %0d want %0d", acc_q.size(), DEPTH + 1); else n_pass++;
    n_checks++;
    if (acc_at(4) !== 16'h0004) $display("FAIL refill_addr: got %h want 0004", acc_at(4)); else n_pass++;
    n_checks++;
    if (bus.mem_req !== 1'b0) $display("FAIL refill_no_req: got %b want 0", bus.mem_req); else n_pass++;
  endtask

  task automatic test_redirect_wait();
    do_reset();
    auto_cack = 1'b1; lat = 3; deq_drv = 1'b0;
    run_until_acc(1, 20);
    tick(1'b1, 16'h0100);
    n_checks++;
    if (bus.mem_req !== 1'b0) $display("FAIL drop_no_req: got %b want 0", bus.mem_req); else n_pass++;
    deq_drv = 1'b1;
    run_until_pops(1, 60);
    n_checks++;
    if (acc_at(1) !== 16'h0100) $display("FAIL redir_wait_addr: got %h want 0100", acc_at(1)); else n_pass++;
    n_checks++;
    if (pop_at(0) !== 16'h0100) $display("FAIL redir_wait_out: got %h want 0100", pop_at(0)); else n_pass++;
  endtask

  task automatic test_redirect_ready_deq();
    do_reset();
    auto_cack = 1'b1; lat = 1; deq_drv = 1'b0;
    run_until_acc(2, 30);
    deq_drv = 1'b1;
    tick(1'b1, 16'h0200);
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL redir_flush: got %b want 0", bus.out_valid); else n_pass++;
    run_until_pops(1, 60);
    n_checks++;
    if (acc_at(2) !== 16'h0200) $display("FAIL redir_ready_addr: got %h want 0200", acc_at(2)); else n_pass++;
    n_checks++;
    if (pop_at(0) !== 16'h0200) $display("FAIL redir_ready_out: got %h want 0200", pop_at(0)); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    tick(1'b1, 16'hFFFF);
    n_checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'hFFFF)
      $display("FAIL idle_redirect: got %b/%h want 1/ffff", bus.mem_req, bus.mem_addr);
    else n_pass++;
    auto_cack = 1'b1; deq_drv = 1'b1;
    run_until_acc(3, 40);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (acc_at(i) !== AW'(16'hFFFF + i)) $display("FAIL wrap[%0d]: got %h want %h", i, acc_at(i), AW'(16'hFFFF + i));
      else n_pass++;
    end
    run_until_pops(1, 20);
    n_checks++;
    if (pop_at(0) !== 16'hFFFF) $display("FAIL wrap_out: got %h want ffff", pop_at(0)); else n_pass++;
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    tick(1'b1, 16'h0040);
    auto_cack = 1'b1; lat = 3;
    run_until_acc(1, 10);
    rst = 1'b1;
    tick(1'b0, '0);
    rst = 1'b0;
    n_checks++;
    if (bus.mem_req !== 1'b0 || bus.out_valid !== 1'b0 || bus.mem_addr !== RVEC)
      $display("FAIL rst_in_wait: got %b/%b/%h want 0/0/%h", bus.mem_req, bus.out_valid, bus.mem_addr, RVEC);
    else n_pass++;
    deq_drv = 1'b1;
    run_until_acc(2, 20);
    n_checks++;
    if (acc_at(1) !== RVEC) $display("FAIL rst_wait_addr: got %h want %h", acc_at(1), RVEC); else n_pass++;
    run_until_pops(1, 30);
    n_checks++;
    if (pop_at(0) !== RVEC) $display("FAIL rst_wait_out: got %h want %h", pop_at(0), RVEC); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    cack_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      deq_drv = ($urandom_range(0, 2) != 0);
      lat     = $urandom_range(1, 3);
      if ($urandom_range(0, 19) == 0) tick(1'b1, AW'($urandom));
      else tick(1'b0, '0);
    end
    n_checks++;
    if (pop_log.size() < 10) $display("FAIL b2b_progress: got %0d pops want >=10", pop_log.size()); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    bus.redirect = 1'b0; bus.pc_in = '0; bus.deq = 1'b0;
    bus.mem_cack = 1'b0; bus.mem_ready = 1'b0; bus.mem_data = '0;
    pend = 1'b0; pend_stale = 1'b0; pend_cnt = 0; pend_addr = '0;
    auto_cack = 1'b0; cack_rand = 1'b0; deq_drv = 1'b0; lat = 1;
    @(posedge clk);
    #1;
    test_reset();
    test_sequential();
    test_full();
    test_redirect_wait();
    test_redirect_ready_deq();
    test_wrap();
    test_reset_in_wait();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
